bit_serial_adder: RTL



---
 rtl/bit_serial_adder.sv | 105 ++++++++++
 1 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial adder built around a single full-adder cell: one result bit per clock, LSB first.
// Define BSA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef BSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_shifted;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cell_sum;
  logic             cell_carry;
  logic             load;
  logic             last;

  assign cell_sum    = a_sr[0] ^ b_sr[0] ^ carry;
  assign cell_carry  = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign res_shifted = {cell_sum, res_sr[WIDTH-1:1]};
  assign last        = (state == RUN) && (cnt == LAST);
  // A new request is only taken when no addition is in flight.
  assign load        = start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      c_out  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
`ifdef BSA_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (load) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= c_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= res_shifted;
        carry  <= cell_carry;
        cnt    <= last ? '0 : cnt + CW'(1);
        // On the MSB step the carry flop holds the carry into the MSB.
        if (last) begin
          sum   <= res_shifted;
          c_out <= cell_carry;
`ifdef BSA_OVERFLOW_EN
          ovf   <= cell_carry ^ carry;
`endif
        end
      end
    end
  end

endmodule
